prod_accum_stage: RTL and testbench
===================================

// Module: prod_accum_stage
// PURPOSE
//  Sequential stage directly downstream of the 4x4 combinational multiplier array.
//  - Captures successive 8-bit unsigned products through a valid/ready handshake.
//  - Sums each group of up to N_TERMS products into an ACC_W-bit accumulator.
//  - Presents each group's sum, term count and overflow flag on an output handshake.
//  - Turns the free-running product array into a dot-product / MAC datapath.
// PARAMETERS
//  ACC_W    12  accumulator and out_sum width; legal range 8..32
//  N_TERMS  4   products per group before auto-close; legal range 1..15
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_prod holds a product this cycle
//  in_ready   out  1      stage accepts in_prod this cycle
//  in_prod    in   8      unsigned product from the multiplier array
//  in_last    in   1      with an accepted product: close the group after this term
//  in_clear   in   1      discard the partial group (honoured in ACCUM only)
//  out_valid  out  1      out_sum/out_cnt/out_ovf hold a completed group
//  out_ready  in   1      downstream takes the result this cycle
//  out_sum    out  ACC_W  group sum, modulo 2^ACC_W
//  out_cnt    out  4      number of terms in the group, 1..N_TERMS
//  out_ovf    out  1      sticky: some addition in the group carried out of ACC_W
// BEHAVIOUR
//  Clock and reset are fixed: one clock, clk; reset rst is asynchronous, active-high.
//  - rst asserted: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
//  - rst mid-group or mid-HOLD: partial sum or pending result is lost; no output pulse.
//  FSM, two states:
//  - ACCUM: in_ready = ~in_clear. out_valid=0.
//  - HOLD: in_ready=0. out_valid=1. Output registers stay stable until the result is taken.
//  Accept = in_valid & in_ready (ACCUM only). On accept:
//  - {c,acc} <= acc + zext(in_prod); ovf <= ovf | c; cnt <= cnt+1.
//  - Close the group when in_last=1 or cnt+1 == N_TERMS:
//    out_sum <= new acc; out_cnt <= cnt+1; out_ovf <= ovf|c; go to HOLD.
//    acc, cnt and ovf reset to 0 in the same edge.
//  - Latency: out_valid rises in the cycle after the closing accept.
//  in_clear in ACCUM:
//  - acc, cnt and ovf go to 0 next edge; in_ready=0 that cycle, so no product is taken.
//  - Clear wins over a simultaneous in_valid; the product stays on the bus, unaccepted.
//  - Clear with cnt=0 is a harmless no-op.
//  - in_clear in HOLD is ignored.
//  HOLD exit:
//  - out_valid & out_ready -> ACCUM next edge; out_valid drops.
//  - No input is accepted in the drain cycle; one bubble per group.
//  - out_sum, out_cnt and out_ovf keep their last values after the drain (don't-care).
//  Arithmetic and width rules:
//  - in_prod is zero-extended, unsigned; wrap is modulo 2^ACC_W.
//  - out_ovf reports any carry in the group even if the final sum wrapped back small.
//  - cnt width is 4 bits. N_TERMS=1 closes the group on every accept.
//  Handshake rules:
//  - in_ready does not depend combinationally on in_valid, only on state and in_clear.
//  - out_valid never drops without out_ready.
// TESTING
//  1 N_TERMS=4: 15,225,0,63 back-to-back -> out_sum=303, out_cnt=4, out_ovf=0.
//    out_valid 1 cycle after the 4th accept.
//  2 ACC_W=8: 225,225,in_last -> out_sum=194 (450 mod 256), out_cnt=2, out_ovf=1.
//    Next group 1,in_last -> out_sum=1, out_ovf=0.
//  3 Backpressure: hold out_ready=0 for 5 cycles in HOLD.
//    -> in_ready=0, outputs stable; drain on out_ready=1, then the next group sums correctly.
//  4 Accept 9,9; then in_clear together with in_valid (prod 4); then 2,in_last.
//    -> the 4 is not taken; out_sum=2, out_cnt=1.
//  5 rst pulse (async, mid-edge) after 2 accepts and again in HOLD.
//    -> all outputs 0 immediately, in_ready=1; the following group sums from 0.
//  6 Random stream of products, valid/ready throttling and in_last.
//    -> each result matches a reference model of group sums, counts and carry flags.

Source files
------------

// File: rtl/prod_accum_stage.sv
// -----------------------------------------------------------------------------
// prod_accum_stage
//
// Sequential stage behind the 4x4 multiplier array. It takes 8-bit unsigned
// products through a valid/ready handshake, sums groups of up to N_TERMS of
// them into an ACC_W-bit accumulator, and presents each finished group on an
// output handshake. Together with the array this forms a dot-product / MAC
// datapath.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer that raises valid keeps it and
// its payload stable until the transfer. in_ready depends only on the FSM
// state and in_clear, never on in_valid. out_valid, once raised, holds until
// out_ready takes the result.
//
// Parameters
//   ACC_W    accumulator / out_sum width, 8..32
//   N_TERMS  products per group before the group closes by itself, 1..15
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_prod holds a product this cycle
//   in_ready   stage accepts in_prod this cycle
//   in_prod    unsigned 8-bit product
//   in_last    with an accepted product: close the group after this term
//   in_clear   discard the partial group (ACCUM only)
//   out_valid  out_sum/out_cnt/out_ovf hold a completed group
//   out_ready  downstream takes the result this cycle
//   out_sum    group sum modulo 2^ACC_W
//   out_cnt    number of terms in the group
//   out_ovf    some addition in the group carried out of ACC_W
//
// The FSM state is held in the signal "state" (ACCUM / HOLD) so that checkers
// can bind to it directly.
// -----------------------------------------------------------------------------
module prod_accum_stage #(
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_cnt,
  output logic             out_ovf
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;   // MSB is the carry out of the accumulator
  logic [3:0]       cnt_nxt;
  logic             accept;
  logic             close;

  // Ready is a pure function of state and clear, so a clear always blocks
  // the product that happens to be on the bus in the same cycle.
  assign in_ready  = (state == ACCUM) & ~in_clear;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, in_prod};
  assign cnt_nxt = cnt + 4'd1;
  assign close   = in_last | (cnt_nxt == 4'(N_TERMS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            if (close) begin
              // Publish the group and start the next one from zero.
              out_sum <= sum_ext[ACC_W-1:0];
              out_cnt <= cnt_nxt;
              out_ovf <= ovf | sum_ext[ACC_W];
              acc     <= '0;
              cnt     <= '0;
              ovf     <= 1'b0;
              state   <= HOLD;
            end else begin
              acc <= sum_ext[ACC_W-1:0];
              cnt <= cnt_nxt;
              ovf <= ovf | sum_ext[ACC_W];
            end
          end
        end
        HOLD: begin
          // Output registers are left untouched here; the drain cycle is the
          // one bubble each group costs on the input side.
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_prod_accum_stage
//
// Two instances share one input stream: dut_a (ACC_W=12) and dut_b (ACC_W=8),
// both with N_TERMS=4. The FSM never looks at the sum, so both stay in
// lockstep and every group is checked at two widths. The reference model
// keeps the exact integer total of each group; the expected sum is that total
// modulo 2^ACC_W and the expected overflow flag is total >= 2^ACC_W (the
// accumulator only grows, so a carry happened iff the true total left range).
// -----------------------------------------------------------------------------
module tb_prod_accum_stage;

  localparam int N_TERMS = 4;
  localparam int SB_W    = 12 + 8 + 4 + 1 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  in_prod  = '0;
  logic        in_last  = 1'b0;
  logic        in_clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [11:0] out_sum_a;
  logic [7:0]  out_sum_b;
  logic [3:0]  out_cnt_a, out_cnt_b;
  logic        out_ovf_a, out_ovf_b;

  prod_accum_stage #(.ACC_W(12), .N_TERMS(N_TERMS)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
    .in_last(in_last), .in_clear(in_clear),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
  );

  prod_accum_stage #(.ACC_W(8), .N_TERMS(N_TERMS)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .in_last(in_last), .in_clear(in_clear),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: {sum_a, sum_b, cnt, ovf_a, ovf_b}
  logic [SB_W-1:0] exp_q[$];
  int m_total = 0;
  int m_cnt   = 0;
  bit send_done = 1'b0;

  function automatic logic [SB_W-1:0] pack_exp(input int total, input int cnt);
    logic [11:0] sa;
    logic [7:0]  sb;
    logic [3:0]  c;
    sa = 12'(total % 4096);
    sb = 8'(total % 256);
    c  = 4'(cnt);
    return {sa, sb, c, (total >= 4096), (total >= 256)};
  endfunction

  task automatic model_accept(input logic [7:0] p, input logic last);
    m_total = m_total + int'(p);
    m_cnt   = m_cnt + 1;
    if (last || m_cnt == N_TERMS) begin
      exp_q.push_back(pack_exp(m_total, m_cnt));
      m_total = 0;
      m_cnt   = 0;
    end
  endtask

  // driver: present one product; returns #1 after the accepting edge
  task automatic send(input logic [7:0] p, input logic last);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        @(posedge clk);
        model_accept(p, last);
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: product %0d not accepted within 200 cycles", p);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // driver: one-cycle clear issued while in ACCUM; returns #1 after the edge
  task automatic do_clear();
    for (int i = 0; i < 200 && out_valid_a; i++) begin
      @(posedge clk);
      #1;
    end
    in_clear = 1'b1;
    @(posedge clk);
    m_total = 0;
    m_cnt   = 0;
    #1;
    in_clear = 1'b0;
  endtask

  // take one result with out_ready=1 and compare against the scoreboard
  task automatic take_result(input string tag);
    logic [SB_W-1:0] e;
    bit got;
    got = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid_a) begin
        got = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if ({out_sum_a, out_sum_b, out_cnt_a, out_ovf_a, out_ovf_b} !== e) begin
          failures++;
          $display("FAIL %s_result: got sum_a=%0d sum_b=%0d cnt=%0d ovf_a=%0d ovf_b=%0d exp sum_a=%0d sum_b=%0d cnt=%0d ovf_a=%0d ovf_b=%0d",
                   tag, out_sum_a, out_sum_b, out_cnt_a, out_ovf_a, out_ovf_b,
                   e[25:14], e[13:6], e[5:2], e[1], e[0]);
        end
        checks++;
        if (out_valid_b !== 1'b1 || out_cnt_b !== e[5:2] || in_ready_a !== 1'b0) begin
          failures++;
          $display("FAIL %s_hold_flags: out_valid_b=%0d cnt_b=%0d in_ready=%0d exp 1 %0d 0",
                   tag, out_valid_b, out_cnt_b, in_ready_a, e[5:2]);
        end
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: out_valid never rose", tag);
    end else if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL %s_drain: out_valid=%0d in_ready=%0d exp 0 1", tag, out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid_a, out_sum_a, out_cnt_a, out_ovf_a, in_ready_a} !== {1'b0, 12'd0, 4'd0, 1'b0, 1'b1} ||
        {out_valid_b, out_sum_b, out_cnt_b, out_ovf_b, in_ready_b} !== {1'b0, 8'd0, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: a v=%0d s=%0d c=%0d o=%0d r=%0d b v=%0d s=%0d c=%0d o=%0d r=%0d exp zeros with ready=1",
               out_valid_a, out_sum_a, out_cnt_a, out_ovf_a, in_ready_a,
               out_valid_b, out_sum_b, out_cnt_b, out_ovf_b, in_ready_b);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // four back-to-back products auto-close at N_TERMS; latency one cycle
  task automatic test_basic();
    send(8'd15, 1'b0);
    send(8'd225, 1'b0);
    send(8'd0, 1'b0);
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: out_valid=%0d exp 0", out_valid_a);
    end
    send(8'd63, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 12'd303 || out_cnt_a !== 4'd4) begin
      failures++;
      $display("FAIL basic_latency: out_valid=%0d sum=%0d cnt=%0d exp 1 303 4",
               out_valid_a, out_sum_a, out_cnt_a);
    end
    take_result("basic");
  endtask

  // 225+225 wraps the 8-bit instance; next group must start with ovf clear
  task automatic test_wrap();
    send(8'd225, 1'b0);
    send(8'd225, 1'b1);
    take_result("wrap");
    send(8'd1, 1'b1);
    take_result("wrap_next");
  endtask

  // out_ready low for 5 cycles in HOLD; valid and clear held high meanwhile
  task automatic test_backpressure();
    logic [11:0] held;
    send(8'd100, 1'b0);
    send(8'd200, 1'b1);
    held = 12'd300;
    in_valid = 1'b1;
    in_prod  = 8'd77;
    in_clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_sum_a !== held || out_cnt_a !== 4'd2) begin
        failures++;
        $display("FAIL bp_hold_%0d: in_ready=%0d out_valid=%0d sum=%0d cnt=%0d exp 0 1 %0d 2",
                 i, in_ready_a, out_valid_a, out_sum_a, out_cnt_a, held);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_clear = 1'b0;
    take_result("bp");
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    take_result("bp_next");
  endtask

  // clear beats a simultaneous valid; the 4 on the bus is never taken
  task automatic test_clear();
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    in_valid = 1'b1;
    in_prod  = 8'd4;
    in_clear = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready: in_ready_a=%0d in_ready_b=%0d exp 0 0", in_ready_a, in_ready_b);
    end
    @(posedge clk);
    m_total = 0;
    m_cnt   = 0;
    #1;
    in_clear = 1'b0;
    send(8'd2, 1'b1);
    take_result("clear");
    // clear on an empty group changes nothing
    do_clear();
    send(8'd5, 1'b1);
    take_result("clear_empty");
  endtask

  task automatic pulse_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_a, out_sum_a, out_cnt_a, out_ovf_a, in_ready_a} !== {1'b0, 12'd0, 4'd0, 1'b0, 1'b1} ||
        {out_valid_b, out_sum_b, out_ovf_b} !== {1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL %s: v=%0d s=%0d c=%0d o=%0d r=%0d vb=%0d sb=%0d ob=%0d exp zeros with ready=1",
               tag, out_valid_a, out_sum_a, out_cnt_a, out_ovf_a, in_ready_a,
               out_valid_b, out_sum_b, out_ovf_b);
    end
    #2;
    rst = 1'b0;
    m_total = 0;
    m_cnt   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    pulse_reset("rst_mid_group");
    send(8'd99, 1'b1);
    pulse_reset("rst_in_hold");
    send(8'd7, 1'b0);
    send(8'd8, 1'b1);
    take_result("after_rst");
  endtask

  task automatic test_random();
    send_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 160; n++) begin
          if ($urandom_range(0, 14) == 0) do_clear();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
        end
        // flush any partial group
        if (m_cnt != 0) send(8'($urandom_range(0, 255)), 1'b1);
        send_done = 1'b1;
      end
      begin
        logic [SB_W-1:0] e;
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < 5000 && !fin; c++) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (out_valid_a && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if ({out_sum_a, out_sum_b, out_cnt_a, out_ovf_a, out_ovf_b} !== e) begin
              failures++;
              $display("FAIL random_result: got sum_a=%0d sum_b=%0d cnt=%0d ovf_a=%0d ovf_b=%0d exp sum_a=%0d sum_b=%0d cnt=%0d ovf_a=%0d ovf_b=%0d",
                       out_sum_a, out_sum_b, out_cnt_a, out_ovf_a, out_ovf_b,
                       e[25:14], e[13:6], e[5:2], e[1], e[0]);
            end
          end
          if (send_done && exp_q.size() == 0 && !(out_valid_a && out_ready)) fin = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        checks++;
        if (!fin) begin
          failures++;
          $display("FAIL random_timeout: %0d results still pending", exp_q.size());
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0 || out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL final_empty: queue=%0d out_valid=%0d exp 0 0", exp_q.size(), out_valid_a);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
